// File: rtl/exp_accel_core.sv
// Integer exponentiation engine (left-to-right square-and-multiply) with an Avalon-MM register file.
// Optional CYCLES register at address 4 is enabled by defining EXP_ACCEL_CYCLE_COUNTER_EN.
//
// state  | meaning
// IDLE   | waiting for CTRL.start
// SQ     | acc <= acc*acc
// MUL    | acc <= acc*(bit ? BASE : 1); last bit commits RESULT
// DONE   | one cycle after completion, returns to IDLE
module exp_accel_core #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              done_o,
    output logic [DATA_W-1:0] export_conduit_readdata
);

    localparam int CNT_W = $clog2(EXP_W + 1);
    localparam int CW    = (EXP_W < DATA_W) ? EXP_W : DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQ,
        S_MUL,
        S_DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   base_q;
    logic [EXP_W-1:0]    exp_q;
    logic [EXP_W-1:0]    exp_sh;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   result_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic                busy;
    logic                done;
    logic                ovf;

    logic [DATA_W-1:0]   mul_b;
    logic [2*DATA_W-1:0] prod;
    logic                prod_hi_nz;
    logic                wr_ctrl;
    logic                start_req;
    logic                clear_req;
    logic [DATA_W-1:0]   rd_mux;

    assign wr_ctrl   = avs_write && (avs_address == 3'd2);
    assign start_req = wr_ctrl && avs_writedata[0] && !busy;
    assign clear_req = wr_ctrl && avs_writedata[1];

    // One shared multiplier: squares in SQ, conditional multiply by BASE in MUL.
    always_comb begin
        mul_b = DATA_W'(1);
        if (state == S_SQ) begin
            mul_b = acc;
        end else if (exp_sh[EXP_W-1]) begin
            mul_b = base_q;
        end
        prod       = (2*DATA_W)'(acc) * (2*DATA_W)'(mul_b);
        prod_hi_nz = |prod[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state    <= S_IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            exp_sh   <= '0;
            acc      <= '0;
            result_q <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (avs_write && !busy) begin
                case (avs_address)
                    3'd0:    base_q <= avs_writedata;
                    3'd1:    exp_q  <= EXP_W'(avs_writedata[CW-1:0]);
                    default: ;
                endcase
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_req) begin
                        exp_sh  <= exp_q;
                        acc     <= DATA_W'(1);
                        bit_cnt <= CNT_W'(EXP_W - 1);
                        ovf     <= 1'b0;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_SQ;
                    end else begin
                        if (clear_req) begin
                            done <= 1'b0;
                        end
                        state <= S_IDLE;
                    end
                end
                S_SQ: begin
                    acc <= prod[DATA_W-1:0];
                    if (prod_hi_nz) begin
                        ovf <= 1'b1;
                    end
                    state <= S_MUL;
                end
                S_MUL: begin
                    acc    <= prod[DATA_W-1:0];
                    exp_sh <= exp_sh << 1;
                    if (prod_hi_nz) begin
                        ovf <= 1'b1;
                    end
                    if (bit_cnt == '0) begin
                        result_q <= prod[DATA_W-1:0];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        state   <= S_SQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef EXP_ACCEL_CYCLE_COUNTER_EN
    logic [DATA_W-1:0] cycles_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cycles_q <= '0;
        end else if (start_req) begin
            cycles_q <= '0;
        end else if (busy && !(&cycles_q)) begin
            cycles_q <= cycles_q + 1'b1;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0:    rd_mux = base_q;
            3'd1:    rd_mux = DATA_W'(exp_q[CW-1:0]);
            3'd2:    rd_mux = DATA_W'({ovf, done, busy});
            3'd3:    rd_mux = result_q;
`ifdef EXP_ACCEL_CYCLE_COUNTER_EN
            3'd4:    rd_mux = cycles_q;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

    assign done_o                  = done;
    assign export_conduit_readdata = result_q;

endmodule

// File: doc/exp_accel_core.md
Name: exp_accel_core

Overview:
- Parametrised integer exponentiation engine: computes BASE^EXP by left-to-right square-and-multiply.
- Result is truncated to DATA_W bits, with a sticky overflow flag.
- Exposes an Avalon-MM slave register file for the Nios/HPS side and a conduit copy of the result for board I/O (HEX/LEDR glue).
- Replaces the fixed 32-bit system-level accelerator with a reusable core of configurable operand and exponent width.

Parameters:
DATA_W, 32, width of BASE, RESULT and the Avalon data bus (8..32)
EXP_W, 8, width of EXP; number of exponent bits processed (1..16)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous active-high reset
avs_address  in  3  word address of register
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  DATA_W  write data
avs_readdata  out  DATA_W  registered read data
done_o  out  1  level: result valid (mirrors STATUS.done)
export_conduit_readdata  out  DATA_W  continuous copy of RESULT register

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-high on reset_reset.
  - Reset clears BASE, EXP, RESULT, the accumulator, busy, done, overflow, avs_readdata and export_conduit_readdata to 0, and puts the FSM in IDLE.
- Register map (word addresses):
  - 0 BASE: R/W.
  - 1 EXP: R/W, low EXP_W bits; upper bits read 0.
  - 2 CTRL (write): bit0 start, bit1 clear_done. STATUS (read): bit0 busy, bit1 done, bit2 overflow; others 0.
  - 3 RESULT: RO.
  - 4 CYCLES: only with the optional feature.
  - Unused addresses read 0 and ignore writes.
- Read timing: 1-cycle fixed read latency; avs_readdata updates the cycle after avs_read and holds otherwise.
- Writes while busy=1:
  - Writes to BASE/EXP are ignored.
  - start is ignored.
  - clear_done is ignored because done is already 0.
- FSM states: IDLE, SQ, MUL, DONE.
  - IDLE, write CTRL.start=1: latch operands, acc<=1, bit index i<=EXP_W-1, overflow<=0, done<=0, busy<=1, then go to SQ.
  - SQ: acc<=acc*acc, truncated to DATA_W; then go to MUL.
  - MUL: acc<=acc*(EXP[i] ? BASE : 1), truncated to DATA_W.
    - If i==0: RESULT<=next acc, busy<=0, done<=1, go to DONE.
    - Else: i<=i-1, go to SQ.
  - DONE: go to IDLE the next cycle. done stays 1 until clear_done is written or a new start.
- Latency:
  - Fixed at 2*EXP_W cycles from the start write to busy falling; it does not depend on exponent value or leading zeros.
  - With the start write in cycle T, busy=1 for cycles T+1..T+2*EXP_W.
  - done and RESULT become visible at T+2*EXP_W+1.
- Arithmetic:
  - Full 2*DATA_W-bit product each step.
  - overflow is set sticky if any upper DATA_W bits of any product are nonzero.
  - RESULT = BASE^EXP mod 2^DATA_W.
- Edge cases:
  - EXP=0 gives 1, including 0^0=1.
  - BASE=0 with EXP>0 gives 0.
  - BASE=1 gives 1 with no overflow.
- Simultaneous start and clear_done in the same write: start wins; done is 0 and the run begins.
- Reset mid-operation: immediate abort to IDLE, all state zeroed, and no done pulse.
- export_conduit_readdata is updated only when RESULT is updated; it does not track the accumulator during a run.

Optional Feature:
- Macro: EXP_ACCEL_CYCLE_COUNTER_EN.
- When defined:
  - Address 4 (CYCLES, RO) holds a DATA_W-bit counter.
  - The counter is cleared on an accepted start and increments every cycle busy=1.
  - It saturates at all-ones and holds its value after done.
  - It reads 2*EXP_W after a normal run.
- When undefined:
  - Address 4 reads 0.
  - No counter logic is present.

Test Plan:
- DATA_W=32, EXP_W=8; BASE=3, EXP=5, start -> busy for exactly 16 cycles; RESULT=243, overflow=0, done_o=1, export_conduit_readdata=243.
- BASE=2, EXP=31 -> RESULT=0x80000000, overflow=0. Then BASE=2, EXP=32 -> RESULT=0, overflow=1.
- EXP=0 with BASE=0, then with BASE=7 -> RESULT=1 both times, overflow=0, still 16 busy cycles.
- During a run of 3^5, write BASE=9 and a second start -> ignored; RESULT=243 and BASE reads 3.
- Start 3^5, assert reset_reset at busy cycle 6 -> all outputs 0 the same cycle, STATUS=0, and done_o never asserts.
- With EXP_ACCEL_CYCLE_COUNTER_EN defined: 5^3 -> RESULT=125, CYCLES reads 16. Then write CTRL=0x2 -> done=0, RESULT still 125.
